// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator: FSM state encoding,
// period-marker computation and duty-word saturation.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } pwm_state_t;

  // Last count value of a 2^width period; it marks the period boundary.
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Requests above a full period make no sense, so clip them to 2^width.
  function automatic logic [31:0] sat_duty(input logic [31:0] d,
                                           input int unsigned width);
    logic [31:0] full;
    full = 32'd1 << width;
    return (d > full) ? full : d;
  endfunction

endpackage

// File: rtl/pwm_duty_buf.sv
// Double-buffered duty word: one-deep pending slot fed by a valid/ready
// handshake, copied into the active register only at a period boundary.
module pwm_duty_buf
  import pwm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           boundary,
  input  logic           duty_valid,
  input  logic [WIDTH:0] duty_data,
  output logic           duty_ready,
  output logic [WIDTH:0] act_duty
);

  logic           pend;
  logic [WIDTH:0] pend_duty;
  logic           take;

  assign duty_ready = !pend;
  assign take       = duty_valid && duty_ready;

  // A word accepted on a boundary cycle lands in the pending slot and
  // waits for the next boundary; it never bypasses straight to active.
  always_ff @(posedge clk) begin
    if (clr) begin
      pend      <= 1'b0;
      pend_duty <= '0;
      act_duty  <= '0;
    end else begin
      if (boundary && pend) begin
        act_duty <= pend_duty;
      end
      pend <= take || (pend && !boundary);
      if (take) begin
        pend_duty <= (WIDTH+1)'(sat_duty(32'(duty_data), WIDTH));
      end
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: compares an external free-running count against a
// buffered duty word; start/stop are aligned to period boundaries.
// Optional feature macro: PWM_PERIOD_CNT_EN adds a 16-bit period_count output.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             duty_valid,
  input  logic [WIDTH:0]   duty_data,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_done,
  output logic             busy
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_count
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));

  pwm_state_t     state;
  pwm_state_t     state_next;
  logic           boundary;
  logic [WIDTH:0] act_duty;
  logic           running;

  assign boundary = (cnt == MAX);
  assign running  = (state == RUN);
  assign busy     = (state != IDLE);

  pwm_duty_buf #(
    .WIDTH(WIDTH)
  ) u_duty_buf (
    .clk        (clk),
    .clr        (clr),
    .boundary   (boundary),
    .duty_valid (duty_valid),
    .duty_data  (duty_data),
    .duty_ready (duty_ready),
    .act_duty   (act_duty)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping en while running only takes effect at the boundary so the
  // current period always completes.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (en) state_next = SYNC;
      SYNC: begin
        if (!en) begin
          state_next = IDLE;
        end else if (boundary) begin
          state_next = RUN;
        end
      end
      RUN:  if (boundary && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pwm         <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm         <= running && ({1'b0, cnt} < act_duty);
      period_done <= running && boundary;
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  // Counts alongside period_done so both change on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      period_count <= '0;
    end else if (running && boundary) begin
      period_count <= period_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: cycle scoreboard fed by a reference
// model, a table of duty values, and hand-written corner-case sequences.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       duty_valid = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [4:0] duty_data = 5'd0;
  logic       duty_ready;
  logic       pwm;
  logic       period_done;
  logic       busy;
`ifdef PWM_PERIOD_CNT_EN
  logic [15:0] period_count;
`endif

  always #5 clk = ~clk;

  pwm_gen #(
    .WIDTH(4)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .cnt          (cnt),
    .en           (en),
    .duty_valid   (duty_valid),
    .duty_data    (duty_data),
    .duty_ready   (duty_ready),
    .pwm          (pwm),
    .period_done  (period_done),
    .busy         (busy)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .period_count (period_count)
`endif
  );

  typedef struct packed {
    logic        pwm;
    logic        done;
    logic        busy;
    logic        ready;
    logic [15:0] pcount;
  } exp_t;

  typedef struct {
    logic [4:0] duty;
    int         exp_high;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[6];

  int         checks = 0;
  int         errors = 0;
  int         high_cnt = 0;
  int         done_cnt = 0;
  logic [3:0] cnt_v = 4'd0;

  // Reference model state: 0 idle, 1 sync, 2 run
  int          m_st = 0;
  int          m_act = 0;
  int          m_pd = 0;
  bit          m_pend = 0;
  logic [15:0] m_pcount = 16'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("pwm", 32'(pwm), 32'(e.pwm));
    chk("period_done", 32'(period_done), 32'(e.done));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("duty_ready", 32'(duty_ready), 32'(e.ready));
`ifdef PWM_PERIOD_CNT_EN
    chk("period_count", 32'(period_count), 32'(e.pcount));
`endif
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic applyStimulus(input bit c, input bit e, input bit dv,
                               input logic [4:0] dd);
    exp_t x;
    int   nst, nact, npd;
    bit   npend, bnd;
    clr        = c;
    en         = e;
    duty_valid = dv;
    duty_data  = dd;
    cnt        = cnt_v;
    bnd        = (cnt_v == 4'd15);
    x          = '0;
    if (c) begin
      nst = 0; nact = 0; npd = 0; npend = 0;
      m_pcount = 16'd0;
    end else begin
      x.pwm  = (m_st == 2) && (int'(cnt_v) < m_act);
      x.done = (m_st == 2) && bnd;
      if (x.done) m_pcount = m_pcount + 16'd1;
      case (m_st)
        0:       nst = e ? 1 : 0;
        1:       nst = !e ? 0 : (bnd ? 2 : 1);
        default: nst = (bnd && !e) ? 0 : 2;
      endcase
      nact = m_act; npd = m_pd; npend = m_pend;
      if (bnd && m_pend) begin
        nact  = m_pd;
        npend = 0;
      end
      if (dv && !m_pend) begin
        npend = 1;
        npd   = (int'(dd) > 16) ? 16 : int'(dd);
      end
    end
    m_st = nst; m_act = nact; m_pd = npd; m_pend = npend;
    x.busy   = (nst != 0);
    x.ready  = !npend;
    x.pcount = m_pcount;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
    cnt_v = cnt_v + 4'd1;
    if (pwm === 1'b1) high_cnt++;
    if (period_done === 1'b1) done_cnt++;
  endtask

  task automatic run(input int n, input bit e);
    repeat (n) applyStimulus(1'b0, e, 1'b0, 5'd0);
  endtask

  task automatic run_to(input logic [3:0] target, input bit e);
    while (cnt_v != target) applyStimulus(1'b0, e, 1'b0, 5'd0);
  endtask

  // Hand over a duty word while idle and let a boundary make it active.
  task automatic load_idle(input logic [4:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, d);
    do applyStimulus(1'b0, 1'b0, 1'b0, 5'd0); while (cnt_v != 4'd0);
  endtask

  initial begin
    tbl[0] = '{duty: 5'd5,  exp_high: 5};
    tbl[1] = '{duty: 5'd0,  exp_high: 0};
    tbl[2] = '{duty: 5'd16, exp_high: 16};
    tbl[3] = '{duty: 5'd31, exp_high: 16};
    tbl[4] = '{duty: 5'd1,  exp_high: 1};
    tbl[5] = '{duty: 5'd15, exp_high: 15};

    // Reset and idle with a free-running count
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    high_cnt = 0; done_cnt = 0;
    run(40, 1'b0);
    chk("idle_pwm_high_cycles", 32'(high_cnt), 32'd0);
    chk("idle_period_done_count", 32'(done_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_duty_ready", 32'(duty_ready), 32'd1);

    // Duty table: two full RUN periods per entry
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
      load_idle(tbl[i].duty);
      run(16, 1'b1);
      high_cnt = 0; done_cnt = 0;
      run(32, 1'b1);
      chk($sformatf("duty%0d_high_cycles", tbl[i].duty), 32'(high_cnt),
          32'(2 * tbl[i].exp_high));
      chk($sformatf("duty%0d_period_done_count", tbl[i].duty), 32'(done_cnt), 32'd2);
      chk($sformatf("duty%0d_busy", tbl[i].duty), 32'(busy), 32'd1);
    end

    // Backpressure: 3 goes pending, 9 is held off until the boundary
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    run_to(4'd0, 1'b0);
    run(16, 1'b1);
    run_to(4'd4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd3);
    chk("hs_ready_after_3", 32'(duty_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd9);
    chk("hs_ready_holds_9", 32'(duty_ready), 32'd0);
    while (cnt_v != 4'd0) applyStimulus(1'b0, 1'b1, 1'b1, 5'd9);
    chk("hs_ready_after_boundary", 32'(duty_ready), 32'd1);
    high_cnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd9);
    chk("hs_ready_after_9", 32'(duty_ready), 32'd0);
    run(15, 1'b1);
    chk("hs_period_duty3", 32'(high_cnt), 32'd3);
    high_cnt = 0;
    run(16, 1'b1);
    chk("hs_period_duty9", 32'(high_cnt), 32'd9);

    // Transfer on the boundary cycle is deferred by one period
    run_to(4'd15, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd12);
    chk("bnd_xfer_ready", 32'(duty_ready), 32'd0);
    high_cnt = 0;
    run(16, 1'b1);
    chk("bnd_xfer_old_duty", 32'(high_cnt), 32'd9);
    high_cnt = 0;
    run(16, 1'b1);
    chk("bnd_xfer_new_duty", 32'(high_cnt), 32'd12);

    // en dropped at cnt 7: the period completes, then IDLE
    high_cnt = 0; done_cnt = 0;
    run(7, 1'b1);
    run(8, 1'b0);
    chk("stop_busy_before_boundary", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    chk("stop_busy_after_boundary", 32'(busy), 32'd0);
    chk("stop_full_period_high", 32'(high_cnt), 32'd12);
    chk("stop_period_done", 32'(done_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    chk("stop_pwm_low", 32'(pwm), 32'd0);

    // clr mid-RUN with a pending word discards everything
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    load_idle(5'd6);
    run(16, 1'b1);
    run_to(4'd4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd10);
    run_to(4'd10, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    chk("clr_pwm", 32'(pwm), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_duty_ready", 32'(duty_ready), 32'd1);
`ifdef PWM_PERIOD_CNT_EN
    chk("clr_period_count", 32'(period_count), 32'd0);
`endif
    run_to(4'd0, 1'b1);
    high_cnt = 0;
    run(16, 1'b1);
    chk("clr_act_duty_zero", 32'(high_cnt), 32'd0);
    chk("clr_rerun_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

- Pulse-width modulator fed by the free-running up-counter.
- Compares the counter value against a double-buffered duty word and drives a registered PWM output.
- Start and stop are synchronised to period boundaries so the output never glitches.
- Accepts new duty values over a valid/ready handshake from the control logic.

## Interface

- WIDTH, 4, width of the incoming count; period = 2^WIDTH cycles
- clk  in  1  clock; all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- cnt  in  WIDTH  count from the up-counter, same clock domain
- en  in  1  run request
- duty_valid  in  1  duty word offered
- duty_data  in  WIDTH+1  requested high time in cycles (0..2^WIDTH)
- duty_ready  out  1  duty word can be accepted
- pwm  out  1  modulated output, registered
- period_done  out  1  one-cycle pulse per completed RUN period
- busy  out  1  state is not IDLE

## Operation

- Boundary event: cnt == 2^WIDTH-1 (MAX). This is the only period marker; cnt does not need to be monotonic.
- Duty path:
  - active register act_duty, one-deep pending register pend_duty with flag pend.
  - duty_ready = !pend.
  - Transfer occurs when duty_valid && duty_ready: pend <= 1, pend_duty <= duty_data saturated to 2^WIDTH.
- Duty load at boundary: if pend at a boundary cycle, act_duty <= pend_duty and pend <= 0. This happens in every state.
- Transfer and boundary in the same cycle: the word goes to pend. It is not bypassed and takes effect at the next boundary.
- FSM states:
  - IDLE: pwm 0. en=1 → SYNC.
  - SYNC: en=0 → IDLE. Boundary with en=1 → RUN.
  - RUN: boundary with en=0 → IDLE. en=0 elsewhere is ignored, so the current period completes.
- pwm(t+1) = (state(t)==RUN) && (cnt(t) < act_duty(t)).
- period_done(t+1) = (state(t)==RUN) && boundary(t).
- busy = (state != IDLE), combinational from state.
- clr mid-operation: state → IDLE, pwm 0, period_done 0, pend 0, act_duty 0. Any in-flight pending word is discarded.

## Timing

- Reset values: pwm 0, period_done 0, busy 0, duty_ready 1; state IDLE, act_duty 0, pend 0.
- Latency:
  - pwm lags cnt by 1 cycle.
  - RUN starts on the cycle where cnt==0 following the boundary seen in SYNC.
  - First pwm high is the cycle after that.
- Duty edge cases:
  - act_duty 0: pwm stays low for the whole period.
  - act_duty 2^WIDTH: pwm stays high for the whole period.
  - act_duty D: pwm high for D consecutive cycles per period.
- duty_ready drops the cycle after a transfer. It rises the cycle after the boundary that consumes the pending word.
- en toggling inside one SYNC window has no effect on pwm.

## Configuration

- PWM_PERIOD_CNT_EN defined:
  - Adds output period_count (out, 16 bits), reset 0.
  - Increments with period_done and wraps 0xFFFF→0.
  - Holds value in IDLE; cleared only by clr.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure

- Package pwm_pkg holds:
  - typedef of the state enum (IDLE, SYNC, RUN);
  - function computing MAX from WIDTH;
  - saturation helper for duty_data.
- Sub-module pwm_duty_buf holds the handshake, pending/active registers and the boundary load.
- The FSM, compare and outputs stay in pwm_gen.

## Test plan

- Reset/idle: clr=1 for 2 cycles, then en=0 with cnt free-running for 40 cycles → pwm=0, busy=0, duty_ready=1, period_done never asserted.
- Basic duty (WIDTH=4): load duty 5, then en=1 → RUN begins at cnt==0; pwm high exactly 5 of every 16 cycles, 1 cycle after cnt 0..4; period_done pulses once per 16 cycles.
- Extremes: duty 0 → pwm constantly 0 in RUN. Duty 16, and also duty_data 31 (saturated to 16) → pwm constantly 1 with no low cycle across boundaries.
- Handshake/backpressure:
  - Send duty 3 mid-period, then offer 9 the next cycle → duty_ready=0 holds 9 off.
  - At the boundary, 3 becomes active and ready rises.
  - 9 is accepted, then applied one boundary later.
- Simultaneous events:
  - Duty transfer on the boundary cycle → new value applied one period later, not immediately.
  - en dropped at cnt=7 in RUN → pwm completes the period, then IDLE; busy falls after the boundary.
- Reset mid-RUN with a pending word: clr at cnt=10 → next cycle pwm=0, busy=0, duty_ready=1. After en re-asserts, act_duty=0 until a new word is loaded. With PWM_PERIOD_CNT_EN, period_count=0.
